serial_receiver: RTL
====================

SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter BAUD_PERIOD, default 10, clocks per bit; the block SHALL support even values from 4 to 65534.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 serial_in  input  1  asynchronous serial line; idles high.
REQ-005 data_ack  input  1  consumer acknowledge of the held byte.
REQ-006 data_out  output  8  last correctly framed byte received.
REQ-007 data_valid  output  1  data_out holds an unacknowledged byte.
REQ-008 frame_error  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 overrun  output  1  sticky flag: a byte was overwritten before it was acknowledged.
REQ-010 rx_busy  output  1  high in every state except IDLE.

Function
REQ-011 Frame format SHALL be: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high); each bit lasts BAUD_PERIOD clocks.
REQ-012 serial_in SHALL pass through a 2-flop synchronizer; all decisions use only the synchronized value (rx_s).
REQ-013 The state machine SHALL have four states: IDLE, START, DATA, STOP.
REQ-014 IDLE->START SHALL occur only on a high-to-low transition of rx_s (previous high, current low); a line held low SHALL never start a frame.
REQ-015 On entering START, the bit counter SHALL clear.
REQ-016 In START, rx_s SHALL be sampled when the counter reaches BAUD_PERIOD/2-1.
REQ-017 If that START sample is high (false start), the block SHALL return to IDLE with no output change.
REQ-018 If that START sample is low, the block SHALL enter DATA with the counter and bit index cleared.
REQ-019 In DATA, rx_s SHALL be sampled each time the counter reaches BAUD_PERIOD-1, then the counter SHALL clear.
REQ-020 Each DATA sample SHALL shift into a shift register as {rx_s, shift[7:1]}.
REQ-021 After the 8th DATA sample, the block SHALL enter STOP.
REQ-022 In STOP, rx_s SHALL be sampled at count BAUD_PERIOD-1, after which the block SHALL return to IDLE.
REQ-023 Stop sample high: data_out SHALL load the shift register and data_valid SHALL be 1 on the next cycle.
REQ-024 Stop sample low: frame_error SHALL pulse for exactly 1 cycle, and data_out and data_valid SHALL be unchanged.
REQ-025 data_ack while data_valid=1 SHALL clear data_valid and overrun on the next cycle; data_ack while data_valid=0 SHALL be ignored.
REQ-026 A good stop with data_valid=1 and data_ack=0 SHALL overwrite data_out, keep data_valid=1, and set overrun.
REQ-027 A good stop in the same cycle as data_ack SHALL load the new byte, keep data_valid=1, and leave overrun clear.
REQ-028 From the start edge on serial_in to data_valid rising, latency SHALL be 9.5*BAUD_PERIOD+2 to +4 clocks (default: 97–99 clocks); the exact value SHALL be fixed and documented by the implementation.
REQ-029 The counter SHALL be 16 bits wide and SHALL never wrap within a bit period.

Reset
REQ-030 When reset=1, the state SHALL be IDLE and data_out=0x00, data_valid=0, frame_error=0, overrun=0, rx_busy=0.
REQ-031 On reset, the shift register, counter and bit index SHALL be 0, and both synchronizer flops SHALL be 1.
REQ-032 Reset SHALL take priority over all other inputs, including during mid-frame.
REQ-033 After reset is released mid-frame, the partial frame SHALL be discarded and no output SHALL change until a new high-to-low edge.

Verification
REQ-034 Send 0xA5 with a good stop bit, P=10 -> data_out=0xA5 and data_valid=1 within 97–99 clocks of the start edge; frame_error=0.
REQ-035 Drive a 3-clock low glitch in idle, P=10 -> return to IDLE; data_valid, frame_error and data_out unchanged.
REQ-036 Send 0x3C with a low stop bit -> frame_error pulses for 1 cycle; data_valid stays 0; a subsequent 0x81 received correctly.
REQ-037 Send 0x11 with no ack, then 0x22 -> data_out=0x22, data_valid=1, overrun=1; data_ack clears both on the next cycle.
REQ-038 Assert reset at bit 4 of 0xFF, then send 0x5A -> only 0x5A is reported; overrun=0.
REQ-039 Send back-to-back frames 0x00 and 0xFF with P=4, acking each -> both bytes received; no errors.

Source files
------------

// File: rtl/serial_receiver.sv
// 8N1 UART-style receiver with 2-flop input synchronizer, mid-bit sampling and held-byte handshake.
// Fixed latency: start edge on serial_in to data_valid rising is 9.5*BAUD_PERIOD+2 clocks.
module serial_receiver #(
    parameter int unsigned BAUD_PERIOD = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       overrun,
    output logic       rx_busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] HALF_LAST = 16'(BAUD_PERIOD / 2 - 1);
    localparam logic [15:0] FULL_LAST = 16'(BAUD_PERIOD - 1);

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic        rx_prev;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            rx_meta     <= serial_in;
            rx_s        <= rx_meta;
            rx_prev     <= rx_s;
            frame_error <= 1'b0;

            // An ack of a held byte clears both flags; a same-cycle good stop below still reloads data_valid.
            if (data_ack && data_valid) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state   <= START;
                        cnt     <= '0;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                        if (rx_s) begin
                            data_out   <= shift;
                            data_valid <= 1'b1;
                            if (data_valid && !data_ack) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
